// File: rtl/cu_data_write_engine_multi_channel_pkg.sv
// Shared types and constants for the compute-unit write engine: buffer line
// formats, CAPI command/response codes and the write engine state encoding.
package cu_data_write_engine_multi_channel_pkg;

  localparam int ARRAY_SIZE_BITS        = 32;
  localparam int ADDRESS_BITS           = 64;
  localparam int CACHELINE_HALF_BITS    = 512;
  localparam int CACHELINE_SIZE_BITS_HF = 7;

  typedef enum logic [2:0] {
    WRITE_ENGINE_IDLE,
    WRITE_ENGINE_SETUP,
    WRITE_ENGINE_RUN,
    WRITE_ENGINE_DRAIN,
    WRITE_ENGINE_DONE
  } write_engine_state_t;

  typedef enum logic [12:0] {
    CMD_NONE   = 13'h0000,
    READ_CL_NA = 13'h0A00,
    WRITE_NA   = 13'h0D00
  } command_t;

  typedef enum logic [1:0] {
    CMD_TYPE_NONE,
    CMD_TYPE_READ,
    CMD_TYPE_WRITE
  } cmd_type_t;

  typedef enum logic [7:0] {
    RSP_DONE   = 8'h00,
    RSP_AERROR = 8'h01,
    RSP_FAILED = 8'h08,
    RSP_PAGED  = 8'h0A
  } response_t;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0]    array_send;
    logic [ARRAY_SIZE_BITS-1:0] size_send;
  } wed_t;

  typedef struct packed {
    wed_t wed;
  } WEDPayload;

  typedef struct packed {
    logic      valid;
    WEDPayload payload;
  } WEDInterface;

  typedef struct packed {
    logic                           valid;
    logic [CACHELINE_HALF_BITS-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic                    valid;
    command_t                command;
    logic [ADDRESS_BITS-1:0] address;
    logic [11:0]             size;
    cmd_type_t               cmd_type;
  } CommandBufferLine;

  typedef struct packed {
    logic      valid;
    response_t response;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
  } BufferStatus;

  function automatic logic [ADDRESS_BITS-1:0] line_address(
    input logic [ADDRESS_BITS-1:0]    base,
    input logic [ARRAY_SIZE_BITS-1:0] idx
  );
    return base + (ADDRESS_BITS'(idx) << CACHELINE_SIZE_BITS_HF);
  endfunction

endpackage

// File: rtl/cu_data_write_engine_multi_channel_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// The pointer starts at N-1 so that input 0 wins first after reset.
module round_robin_priority_arbiter_N_input #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         enable,
  input  logic [N-1:0] requests,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    ptr_d       = ptr_q;
    idx         = '0;
    for (int off = 1; off <= N; off++) begin
      idx = PTR_W'((int'(ptr_q) + off) % N);
      if (enable && !grant_valid && requests[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        ptr_d       = idx;
      end
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) ptr_q <= PTR_RESET;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cu_data_write_engine_multi_channel.sv
// Multi-channel cache-line write engine: arbitrates producer channels, issues
// WRITE_NA commands to consecutive lines and tracks credits and completions.
module cu_data_write_engine_multi_channel
  import cu_data_write_engine_multi_channel_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ELEMS_PER_LINE  = 32
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled_in,
  input  WEDInterface                wed_request_in,
  input  ReadWriteDataLine           write_data_0_in [NUM_CHANNELS],
  input  ReadWriteDataLine           write_data_1_in [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]    write_data_ready_out,
  input  BufferStatus                write_command_buffer_status,
  input  ResponseBufferLine          write_response_in,
  output CommandBufferLine           write_command_out,
  output ReadWriteDataLine           write_data_0_out,
  output ReadWriteDataLine           write_data_1_out,
  output logic [ARRAY_SIZE_BITS-1:0] write_job_counter_done,
  output logic                       write_engine_done_out,
  output logic                       write_error_out
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ARRAY_SIZE_BITS:0] ELEMS = (ARRAY_SIZE_BITS + 1)'(ELEMS_PER_LINE);

  write_engine_state_t        state_q, state_d;
  logic [ADDRESS_BITS-1:0]    base_q, base_d;
  logic [ARRAY_SIZE_BITS-1:0] size_q, size_d;
  logic [ARRAY_SIZE_BITS-1:0] lines_q, lines_d;
  logic [ARRAY_SIZE_BITS-1:0] line_idx_q, line_idx_d;
  logic [OUT_W-1:0]           outstanding_q, outstanding_d;
  logic [ARRAY_SIZE_BITS-1:0] done_cnt_q, done_cnt_d;
  logic                       error_q, error_d;
  CommandBufferLine           cmd_q, cmd_d;
  ReadWriteDataLine           data0_q, data0_d;
  ReadWriteDataLine           data1_q, data1_d;

  logic [NUM_CHANNELS-1:0]    requests, grant;
  logic                       grant_any, issue_ok, run_en, engine_done, resp_accept;
  logic [ARRAY_SIZE_BITS:0]   done_sum;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) requests[i] = write_data_0_in[i].valid;
  end

  assign issue_ok = !write_command_buffer_status.alfull && !write_command_buffer_status.full &&
                    (outstanding_q < MAX_OUT) && (line_idx_q < lines_q) && enabled_in;

  round_robin_priority_arbiter_N_input #(.N(NUM_CHANNELS)) u_arbiter (
    .clock       (clock),
    .rstn        (rstn),
    .enable      (run_en),
    .requests    (requests),
    .grant       (grant),
    .grant_valid (grant_any)
  );

  // Next-state logic; DRAIN looks at the post-response count so DONE rises
  // in the same edge that retires the last response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WRITE_ENGINE_IDLE:  if (enabled_in && wed_request_in.valid) state_d = WRITE_ENGINE_SETUP;
      WRITE_ENGINE_SETUP: state_d = (size_q == '0) ? WRITE_ENGINE_DONE : WRITE_ENGINE_RUN;
      WRITE_ENGINE_RUN:   if (line_idx_d == lines_q || !enabled_in) state_d = WRITE_ENGINE_DRAIN;
      WRITE_ENGINE_DRAIN: begin
        if (outstanding_d == '0) begin
          if (line_idx_q == lines_q) state_d = WRITE_ENGINE_DONE;
          else if (!enabled_in)      state_d = WRITE_ENGINE_IDLE;
        end
      end
      WRITE_ENGINE_DONE:  if (!enabled_in) state_d = WRITE_ENGINE_IDLE;
      default:            state_d = WRITE_ENGINE_IDLE;
    endcase
  end

  always_comb begin
    run_en      = (state_q == WRITE_ENGINE_RUN) && issue_ok;
    engine_done = (state_q == WRITE_ENGINE_DONE);
  end

  always_comb begin
    base_d      = base_q;
    size_d      = size_q;
    lines_d     = lines_q;
    line_idx_d  = line_idx_q;
    done_cnt_d  = done_cnt_q;
    error_d     = error_q;
    cmd_d       = '0;
    data0_d     = '0;
    data1_d     = '0;
    resp_accept = write_response_in.valid && (outstanding_q != '0);
    done_sum    = {1'b0, done_cnt_q} + ELEMS;

    // Responses with nothing outstanding are dropped but flagged.
    if (write_response_in.valid) begin
      if (!resp_accept || write_response_in.response != RSP_DONE) error_d = 1'b1;
      else if (done_sum >= {1'b0, size_q})                        done_cnt_d = size_q;
      else                                                         done_cnt_d = done_sum[ARRAY_SIZE_BITS-1:0];
    end

    outstanding_d = outstanding_q + OUT_W'(grant_any) - OUT_W'(resp_accept);

    if (grant_any) begin
      line_idx_d     = line_idx_q + 1'b1;
      cmd_d.valid    = 1'b1;
      cmd_d.command  = WRITE_NA;
      cmd_d.address  = line_address(base_q, line_idx_q);
      cmd_d.size     = 12'd128;
      cmd_d.cmd_type = CMD_TYPE_WRITE;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (grant[i]) begin
          data0_d = write_data_0_in[i];
          data1_d = write_data_1_in[i];
        end
      end
      data0_d.valid = 1'b1;
      data1_d.valid = 1'b1;
    end

    case (state_q)
      WRITE_ENGINE_IDLE: begin
        if (enabled_in && wed_request_in.valid) begin
          base_d = wed_request_in.payload.wed.array_send;
          size_d = wed_request_in.payload.wed.size_send;
        end
      end
      WRITE_ENGINE_SETUP: begin
        lines_d       = ARRAY_SIZE_BITS'(({1'b0, size_q} + ELEMS - 1'b1) / ELEMS);
        line_idx_d    = '0;
        outstanding_d = '0;
        done_cnt_d    = '0;
        error_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= WRITE_ENGINE_IDLE;
      base_q        <= '0;
      size_q        <= '0;
      lines_q       <= '0;
      line_idx_q    <= '0;
      outstanding_q <= '0;
      done_cnt_q    <= '0;
      error_q       <= 1'b0;
      cmd_q         <= '0;
      data0_q       <= '0;
      data1_q       <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      size_q        <= size_d;
      lines_q       <= lines_d;
      line_idx_q    <= line_idx_d;
      outstanding_q <= outstanding_d;
      done_cnt_q    <= done_cnt_d;
      error_q       <= error_d;
      cmd_q         <= cmd_d;
      data0_q       <= data0_d;
      data1_q       <= data1_d;
    end
  end

  assign write_data_ready_out   = grant;
  assign write_command_out      = cmd_q;
  assign write_data_0_out       = data0_q;
  assign write_data_1_out       = data1_q;
  assign write_job_counter_done = done_cnt_q;
  assign write_engine_done_out  = engine_done;
  assign write_error_out        = error_q;

endmodule

// File: tb/tb_cu_data_write_engine_multi_channel.sv
// Directed bench for the multi-channel write engine: issue order, credit limit,
// partial lines, alfull back-pressure, error flag and mid-job reset.
module tb_cu_data_write_engine_multi_channel;
  import cu_data_write_engine_multi_channel_pkg::*;

  localparam int NCH  = 2;
  localparam int MAXO = 4;
  localparam int EPL  = 32;
  localparam int AUTO = 1000000;

  logic              clock = 1'b0;
  logic              rstn;
  logic              enabled_in;
  WEDInterface       wed;
  ReadWriteDataLine  wd0 [NCH];
  ReadWriteDataLine  wd1 [NCH];
  logic [NCH-1:0]    ready;
  BufferStatus       bstat;
  ResponseBufferLine resp;
  CommandBufferLine  cmd;
  ReadWriteDataLine  d0o, d1o;
  logic [31:0]       cnt;
  logic              done, err;

  cu_data_write_engine_multi_channel #(
    .NUM_CHANNELS(NCH), .MAX_OUTSTANDING(MAXO), .ELEMS_PER_LINE(EPL)
  ) dut (
    .clock                       (clock),
    .rstn                        (rstn),
    .enabled_in                  (enabled_in),
    .wed_request_in              (wed),
    .write_data_0_in             (wd0),
    .write_data_1_in             (wd1),
    .write_data_ready_out        (ready),
    .write_command_buffer_status (bstat),
    .write_response_in           (resp),
    .write_command_out           (cmd),
    .write_data_0_out            (d0o),
    .write_data_1_out            (d1o),
    .write_job_counter_done      (cnt),
    .write_engine_done_out       (done),
    .write_error_out             (err)
  );

  always #5 clock = ~clock;

  int          tests, fails, step_no;
  int          cmd_count, resp_count, resp_credit, last_resp_step, done_step;
  bit          stray_resp;
  response_t   resp_type;
  logic [63:0] cmd_addr [$];
  int          cmd_chan [$];
  int          cmd_step [$];

  // One clock: observe outputs 1 ns after the edge, then drive the response for the next edge.
  task automatic step();
    @(posedge clock);
    #1;
    step_no++;
    if (cmd.valid) begin
      int ch;
      ch = int'(d0o.data[7:0]) - 32'hA0;
      cmd_addr.push_back(cmd.address);
      cmd_chan.push_back(ch);
      cmd_step.push_back(step_no);
      cmd_count++;
      tests++;
      if (!d0o.valid || !d1o.valid || d0o.data !== 512'(32'hA0 + ch) || d1o.data !== 512'(32'hB0 + ch) ||
          cmd.command !== WRITE_NA || cmd.size !== 12'd128 || cmd.cmd_type !== CMD_TYPE_WRITE) begin
        fails++;
        $display("FAIL cmd_fields: valids=%0b%0b cmd=%h size=%0d type=%0d d1=%h, required 11 0d00 128 2 %h",
                 d0o.valid, d1o.valid, cmd.command, cmd.size, cmd.cmd_type, d1o.data[7:0], 32'hB0 + ch);
      end
    end
    if (stray_resp) begin
      resp.valid = 1'b1; resp.response = resp_type; stray_resp = 1'b0;
    end else if (cmd_count > resp_count && resp_credit > 0) begin
      resp.valid = 1'b1; resp.response = resp_type;
      resp_count++; resp_credit--; last_resp_step = step_no;
    end else begin
      resp.valid = 1'b0;
    end
  endtask

  task automatic drive_channels(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) begin
      wd0[i].valid = v[i]; wd0[i].data = 512'(32'hA0 + i);
      wd1[i].valid = v[i]; wd1[i].data = 512'(32'hB0 + i);
    end
  endtask

  task automatic clear_log();
    cmd_addr.delete(); cmd_chan.delete(); cmd_step.delete();
    cmd_count = 0; resp_count = 0; last_resp_step = -1; done_step = -1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; resp.valid = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();
    clear_log();
  endtask

  task automatic start_job(input logic [63:0] base, input int n);
    clear_log();
    wed.valid = 1'b1;
    wed.payload.wed.array_send = base;
    wed.payload.wed.size_send = 32'(n);
    enabled_in = 1'b1;
    step();
    wed.valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int k;
    k = 0;
    while (!done && k < max_cycles) begin step(); k++; end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, k);
    end else done_step = step_no;
  endtask

  task automatic end_job(input string name);
    enabled_in = 1'b0;
    step(); step();
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL %s_idle: done=%0b, required 0", name, done); end
  endtask

  task automatic check_lines(input string name, input logic [63:0] base, input int lines);
    tests++;
    if (cmd_count != lines) begin
      fails++; $display("FAIL %s_count: %0d commands, required %0d", name, cmd_count, lines);
    end else begin
      for (int i = 0; i < lines; i++) begin
        tests++;
        if (cmd_addr[i] !== base + 64'(i * 128)) begin
          fails++; $display("FAIL %s_addr%0d: %h, required %h", name, i, cmd_addr[i], base + 64'(i * 128));
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_channels(2'b11);
    step(); step();
    tests++;
    if (cmd.valid !== 1'b0 || d0o.valid !== 1'b0 || d1o.valid !== 1'b0 || ready !== '0) begin
      fails++; $display("FAIL reset_valids: %0b%0b%0b ready=%b, required 000 00", cmd.valid, d0o.valid, d1o.valid, ready);
    end
    tests++;
    if (cnt !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL reset_status: cnt=%0d done=%0b err=%0b, required 0 0 0", cnt, done, err);
    end
    rstn = 1'b1;
    step(); step();
    tests++;
    if (ready !== '0) begin fails++; $display("FAIL idle_no_grant: ready=%b, required 00", ready); end
    clear_log();
  endtask

  task automatic test_single_channel();
    drive_channels(2'b01);
    start_job(64'h1000, 64);
    wait_done(100, "single");
    check_lines("single", 64'h1000, 2);
    for (int i = 0; i < cmd_count; i++) begin
      tests++;
      if (cmd_chan[i] != 0) begin fails++; $display("FAIL single_chan%0d: %0d, required 0", i, cmd_chan[i]); end
    end
    tests++;
    if (cnt !== 32'd64) begin fails++; $display("FAIL single_count: %0d, required 64", cnt); end
    tests++;
    if (done_step - last_resp_step != 1) begin
      fails++; $display("FAIL single_done_latency: %0d cycles, required 1", done_step - last_resp_step);
    end
    end_job("single");
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_channels(2'b11);
    start_job(64'h2000, 128);
    wait_done(100, "b2b");
    check_lines("b2b", 64'h2000, 4);
    for (int i = 0; i < cmd_count; i++) begin
      tests++;
      if (cmd_chan[i] != i % 2) begin fails++; $display("FAIL b2b_chan%0d: %0d, required %0d", i, cmd_chan[i], i % 2); end
      if (i > 0) begin
        tests++;
        if (cmd_step[i] != cmd_step[i-1] + 1) begin
          fails++; $display("FAIL b2b_gap%0d: step %0d, required %0d", i, cmd_step[i], cmd_step[i-1] + 1);
        end
      end
    end
    tests++;
    if (cnt !== 32'd128) begin fails++; $display("FAIL b2b_count: %0d, required 128", cnt); end
    end_job("b2b");
  endtask

  task automatic test_outstanding_limit();
    drive_channels(2'b11);
    resp_credit = 0;
    start_job(64'h4000, 256);
    repeat (12) step();
    tests++;
    if (cmd_count != MAXO) begin fails++; $display("FAIL limit_stall: %0d commands, required %0d", cmd_count, MAXO); end
    resp_credit = 1;
    repeat (8) step();
    tests++;
    if (cmd_count != MAXO + 1) begin fails++; $display("FAIL limit_release: %0d commands, required %0d", cmd_count, MAXO + 1); end
    resp_credit = AUTO;
    wait_done(100, "limit");
    check_lines("limit", 64'h4000, 8);
    tests++;
    if (cnt !== 32'd256) begin fails++; $display("FAIL limit_count: %0d, required 256", cnt); end
    end_job("limit");
  endtask

  task automatic test_partial_line();
    drive_channels(2'b11);
    start_job(64'h6000, 40);
    wait_done(100, "partial");
    check_lines("partial", 64'h6000, 2);
    tests++;
    if (cnt !== 32'd40) begin fails++; $display("FAIL partial_count: %0d, required 40", cnt); end
    end_job("partial");
    start_job(64'h7000, 0);
    wait_done(10, "zero");
    tests++;
    if (cmd_count != 0 || cnt !== 32'd0) begin
      fails++; $display("FAIL zero_job: %0d commands cnt=%0d, required 0 0", cmd_count, cnt);
    end
    resp_type = RSP_DONE;
    stray_resp = 1'b1;
    step(); step();
    tests++;
    if (err !== 1'b1 || cnt !== 32'd0) begin
      fails++; $display("FAIL stray_response: err=%0b cnt=%0d, required 1 0", err, cnt);
    end
    end_job("zero");
  endtask

  task automatic test_alfull();
    int c;
    drive_channels(2'b11);
    start_job(64'h8000, 320);
    c = 0;
    while (!done && c < 200) begin
      step();
      c++;
      bstat.alfull = (c >= 3 && c < 6);
      #1;
      if (bstat.alfull) begin
        tests++;
        if (ready !== '0) begin fails++; $display("FAIL alfull_grant: ready=%b at cycle %0d, required 00", ready, c); end
      end
    end
    bstat.alfull = 1'b0;
    tests++;
    if (!done) begin fails++; $display("FAIL alfull_timeout: done=%0b, required 1", done); end
    check_lines("alfull", 64'h8000, 10);
    tests++;
    if (cnt !== 32'd320 || err !== 1'b0) begin
      fails++; $display("FAIL alfull_status: cnt=%0d err=%0b, required 320 0", cnt, err);
    end
    end_job("alfull");
  endtask

  task automatic test_error_reset();
    int k;
    drive_channels(2'b11);
    resp_credit = 0;
    start_job(64'hA000, 256);
    k = 0;
    while (cmd_count < 2 && k < 20) begin step(); k++; end
    resp_type = RSP_FAILED;
    resp_credit = 1;
    step(); step(); step();
    tests++;
    if (err !== 1'b1 || cnt !== 32'd0) begin
      fails++; $display("FAIL failed_response: err=%0b cnt=%0d, required 1 0", err, cnt);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (cmd.valid !== 1'b0 || d0o.valid !== 1'b0 || d1o.valid !== 1'b0 || ready !== '0 ||
        cnt !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL midjob_reset: %0b%0b%0b ready=%b cnt=%0d done=%0b err=%0b, required all 0",
                        cmd.valid, d0o.valid, d1o.valid, ready, cnt, done, err);
    end
    resp.valid = 1'b0;
    resp_credit = 0;
    enabled_in = 1'b0;
    step(); step();
    clear_log();
    rstn = 1'b1;
    resp_type = RSP_DONE;
    resp_credit = AUTO;
    step();
    start_job(64'hC000, 64);
    wait_done(100, "after_reset");
    check_lines("after_reset", 64'hC000, 2);
    tests++;
    if (cmd_count == 2 && (cmd_chan[0] != 0 || cmd_chan[1] != 1)) begin
      fails++; $display("FAIL after_reset_chan: %0d %0d, required 0 1", cmd_chan[0], cmd_chan[1]);
    end
    tests++;
    if (cnt !== 32'd64 || err !== 1'b0) begin
      fails++; $display("FAIL after_reset_status: cnt=%0d err=%0b, required 64 0", cnt, err);
    end
    end_job("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; step_no = 0;
    rstn = 1'b0; enabled_in = 1'b0;
    wed = '0; bstat = '0; resp = '0;
    stray_resp = 1'b0; resp_type = RSP_DONE; resp_credit = AUTO;
    drive_channels('0);
    clear_log();
    test_reset();
    test_single_channel();
    test_back_to_back();
    test_outstanding_limit();
    test_partial_line();
    test_alfull();
    test_error_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
